sequence_generator_20161311: RTL and testbench



---
 rtl/sequence_generator_20161311_if.sv | 30 +++
 rtl/sequence_generator_20161311.sv | 151 +++++++++++++++
 tb/tb_sequence_generator_20161311.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_20161311_if.sv
// ---------------------------------------------------------------------------
// sequence_generator_20161311_if
// Digit stream carried from the 20161311 sequence generator to its sink
// (normally the sequence detector's in_num input).
//   out_num   : current 4-bit BCD digit
//   out_valid : out_num holds a digit offered to the sink
//   out_ready : sink accepts the digit; a transfer is out_valid && out_ready
//   out_last  : marks digit index 7 of each repetition
// master = generator side, slave = sink side.
// ---------------------------------------------------------------------------
interface sequence_generator_20161311_if;
   logic [3:0] out_num;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (
      output out_num,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_num,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/sequence_generator_20161311.sv
// ---------------------------------------------------------------------------
// sequence_generator_20161311
// Emits the BCD digit sequence 2,0,1,6,1,3,1,1 over a valid/ready stream,
// repeated 'reps' times (0 means once), optionally with GAP_CYCLES idle
// cycles after every digit except the very last one.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : begin a transmission (only looked at in IDLE)
//   reps   : repetition count, latched with an accepted start
//   abort  : cancel the transmission in progress, back to IDLE, no done
//   stream : digit stream (out_num/out_valid/out_last out, out_ready in)
//   busy   : high in SEND, GAP and DONE
//   done   : one-cycle pulse after the final digit has been transferred
// All outputs are registers, so there is no input-to-output comb path.
// ---------------------------------------------------------------------------
module sequence_generator_20161311 #(
   parameter int GAP_CYCLES = 0,
   parameter int REP_W      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [REP_W-1:0]             reps,
   input  logic                         abort,
   sequence_generator_20161311_if.master stream,
   output logic                         busy,
   output logic                         done
);

   // Gap counter runs 0..GAP_CYCLES-1; with no gaps it is never used and
   // gets trimmed away.
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t           state;
   logic [2:0]       idx;
   logic [REP_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_cnt;

   // idx is 3 bits wide, so 7+1 wraps to 0 for the next repetition.
   logic [2:0] idx_nxt;
   logic       final_rep;
   assign idx_nxt   = idx + 3'd1;
   assign final_rep = (rep_cnt == REP_W'(1));

   function automatic logic [3:0] digit_of(input logic [2:0] i);
      logic [3:0] d;
      case (i)
         3'd0:    d = 4'd2;
         3'd1:    d = 4'd0;
         3'd2:    d = 4'd1;
         3'd3:    d = 4'd6;
         3'd4:    d = 4'd1;
         3'd5:    d = 4'd3;
         3'd6:    d = 4'd1;
         default: d = 4'd1;
      endcase
      return d;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         idx              <= 3'd0;
         rep_cnt          <= '0;
         gap_cnt          <= '0;
         stream.out_valid <= 1'b0;
         stream.out_num   <= 4'd0;
         stream.out_last  <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         done <= 1'b0;
         // Abort outranks a same-cycle transfer and the final transfer's
         // done; a digit accepted in this cycle is simply not resent.
         if (abort && state != IDLE) begin
            state            <= IDLE;
            idx              <= 3'd0;
            rep_cnt          <= '0;
            gap_cnt          <= '0;
            stream.out_valid <= 1'b0;
            stream.out_num   <= 4'd0;
            stream.out_last  <= 1'b0;
            busy             <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state            <= SEND;
                     idx              <= 3'd0;
                     rep_cnt          <= (reps == '0) ? REP_W'(1) : reps;
                     stream.out_valid <= 1'b1;
                     stream.out_num   <= digit_of(3'd0);
                     stream.out_last  <= 1'b0;
                     busy             <= 1'b1;
                  end
               end
               SEND: begin
                  // Without out_ready everything holds, keeping the offer stable.
                  if (stream.out_ready) begin
                     if (idx == 3'd7 && final_rep) begin
                        state            <= DONE;
                        idx              <= 3'd0;
                        rep_cnt          <= '0;
                        stream.out_valid <= 1'b0;
                        stream.out_num   <= 4'd0;
                        stream.out_last  <= 1'b0;
                        done             <= 1'b1;
                     end else begin
                        idx <= idx_nxt;
                        if (idx == 3'd7) rep_cnt <= rep_cnt - REP_W'(1);
                        if (GAP_CYCLES > 0) begin
                           state            <= GAP;
                           gap_cnt          <= '0;
                           stream.out_valid <= 1'b0;
                           stream.out_num   <= 4'd0;
                           stream.out_last  <= 1'b0;
                        end else begin
                           stream.out_num  <= digit_of(idx_nxt);
                           stream.out_last <= (idx_nxt == 3'd7);
                        end
                     end
                  end
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     state            <= SEND;
                     gap_cnt          <= '0;
                     stream.out_valid <= 1'b1;
                     stream.out_num   <= digit_of(idx);
                     stream.out_last  <= (idx == 3'd7);
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sequence_generator_20161311.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator_20161311
// Bench for sequence_generator_20161311: one instance without gaps (dut0)
// and one with GAP_CYCLES=2 (dut2). Expected digits are queued when a start
// is driven and popped when the generator transfers a digit.
// ---------------------------------------------------------------------------
module tb_sequence_generator_20161311;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, abort0, start2, abort2;
   logic [3:0] reps0, reps2;
   logic       busy0, done0, busy2, done2;

   sequence_generator_20161311_if if0();
   sequence_generator_20161311_if if2();

   sequence_generator_20161311 #(.GAP_CYCLES(0), .REP_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .reps(reps0), .abort(abort0),
      .stream(if0), .busy(busy0), .done(done0));

   sequence_generator_20161311 #(.GAP_CYCLES(2), .REP_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .reps(reps2), .abort(abort2),
      .stream(if2), .busy(busy2), .done(done2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [3:0] dig [8] = '{4'd2, 4'd0, 4'd1, 4'd6, 4'd1, 4'd3, 4'd1, 4'd1};
   logic [4:0] q0 [$];
   logic [4:0] q2 [$];

   // dut0 monitor state
   int   cyc = 0;
   int   base = 0;
   int   n_xfer, n_done, first_x, last_x, done_cyc;
   bit   pstall = 0;
   logic [3:0] pnum;
   logic       plast;
   logic [4:0] e0;

   always @(negedge clk) begin
      cyc++;
      if (rst_n !== 1'b1) begin
         pstall = 0;
      end else begin
         if (pstall) begin
            checks++;
            if (if0.out_valid !== 1'b1 || if0.out_num !== pnum || if0.out_last !== plast) begin
               errors++;
               $display("FAIL stall_hold: got valid=%b num=%0d last=%b, required valid=1 num=%0d last=%b",
                        if0.out_valid, if0.out_num, if0.out_last, pnum, plast);
            end
         end
         if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("FAIL extra_digit: got num=%0d last=%b, required no transfer", if0.out_num, if0.out_last);
            end else begin
               e0 = q0.pop_front();
               if ({if0.out_last, if0.out_num} !== e0) begin
                  errors++;
                  $display("FAIL digit: got num=%0d last=%b, required num=%0d last=%b",
                           if0.out_num, if0.out_last, e0[3:0], e0[4]);
               end
            end
            if (n_xfer == 0) first_x = cyc;
            last_x = cyc;
            n_xfer++;
         end
         if (done0 === 1'b1) begin
            n_done++;
            done_cyc = cyc;
         end
         pstall = (if0.out_valid === 1'b1) && (if0.out_ready !== 1'b1);
         pnum   = if0.out_num;
         plast  = if0.out_last;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear0();
      n_xfer = 0; n_done = 0; first_x = -1; last_x = -1; done_cyc = -1;
   endtask

   task automatic push0_n(input int n);
      for (int i = 0; i < n; i++) q0.push_back({((i % 8) == 7), dig[i % 8]});
   endtask

   // Drive start for one edge; cycle base+k is the k-th cycle after that edge.
   task automatic go0(input int r);
      start0 = 1'b1; reps0 = 4'(r);
      tick(1);
      start0 = 1'b0;
      base = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start0 = 0; abort0 = 0; reps0 = 0; start2 = 0; abort2 = 0; reps2 = 0;
      if0.out_ready = 1'b1; if2.out_ready = 1'b1;
      tick(3);
      checks++; if ({if0.out_valid, if0.out_num, if0.out_last, busy0, done0} !== 8'h00) begin errors++;
         $display("FAIL reset_dut0: got valid=%b num=%0d last=%b busy=%b done=%b, required all 0", if0.out_valid, if0.out_num, if0.out_last, busy0, done0); end
      checks++; if ({if2.out_valid, if2.out_num, if2.out_last, busy2, done2} !== 8'h00) begin errors++;
         $display("FAIL reset_dut2: got valid=%b num=%0d last=%b busy=%b done=%b, required all 0", if2.out_valid, if2.out_num, if2.out_last, busy2, done2); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_single();
      clear0(); if0.out_ready = 1'b1;
      push0_n(8); go0(1); tick(12);
      checks++; if (n_xfer != 8) begin errors++; $display("FAIL single_count: got %0d, required 8", n_xfer); end
      checks++; if (first_x != base + 1) begin errors++; $display("FAIL single_first: got %0d, required %0d", first_x - base, 1); end
      checks++; if (last_x != base + 8) begin errors++; $display("FAIL single_last: got %0d, required %0d", last_x - base, 8); end
      checks++; if (n_done != 1 || done_cyc != base + 9) begin errors++; $display("FAIL single_done: got %0d pulses at %0d, required 1 at 9", n_done, done_cyc - base); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, required 0", busy0); end
      checks++; if (q0.size() != 0) begin errors++; $display("FAIL single_left: got %0d pending, required 0", q0.size()); end
   endtask

   task automatic test_reps();
      clear0(); push0_n(24); go0(3); tick(30);
      checks++; if (n_xfer != 24 || first_x != base + 1 || last_x != base + 24) begin errors++;
         $display("FAIL reps3_stream: got %0d digits in cycles %0d..%0d, required 24 in 1..24", n_xfer, first_x - base, last_x - base); end
      checks++; if (n_done != 1 || done_cyc != base + 25) begin errors++; $display("FAIL reps3_done: got %0d pulses at %0d, required 1 at 25", n_done, done_cyc - base); end
      clear0(); push0_n(8); go0(0); tick(12);
      checks++; if (n_xfer != 8 || last_x != base + 8) begin errors++; $display("FAIL reps0_stream: got %0d digits, last at %0d, required 8 at 8", n_xfer, last_x - base); end
      checks++; if (n_done != 1 || done_cyc != base + 9) begin errors++; $display("FAIL reps0_done: got %0d pulses at %0d, required 1 at 9", n_done, done_cyc - base); end
   endtask

   task automatic test_back_to_back();
      clear0(); push0_n(8); go0(1); tick(9);
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b, required 0", busy0); end
      push0_n(8);
      start0 = 1'b1; reps0 = 4'd1; tick(1); start0 = 1'b0;
      tick(14);
      checks++; if (n_xfer != 16 || last_x != base + 18) begin errors++; $display("FAIL b2b_stream: got %0d digits, last at %0d, required 16 at 18", n_xfer, last_x - base); end
      checks++; if (n_done != 2 || done_cyc != base + 19) begin errors++; $display("FAIL b2b_done: got %0d pulses, last at %0d, required 2, last at 19", n_done, done_cyc - base); end
   endtask

   task automatic test_backpressure();
      int k;
      clear0(); push0_n(8);
      if0.out_ready = 1'b0;
      go0(1);
      for (k = 0; k < 400 && n_done == 0; k++) begin
         if0.out_ready = 1'($urandom_range(0, 1));
         tick(1);
      end
      if0.out_ready = 1'b1;
      checks++; if (n_done != 1) begin errors++; $display("FAIL bp_timeout: got %0d done pulses, required 1", n_done); end
      checks++; if (n_xfer != 8 || q0.size() != 0) begin errors++; $display("FAIL bp_count: got %0d digits, %0d pending, required 8 and 0", n_xfer, q0.size()); end
      tick(2);
   endtask

   task automatic test_abort();
      clear0(); if0.out_ready = 1'b1;
      push0_n(5); go0(1); tick(4);
      checks++; if (if0.out_valid !== 1'b1 || if0.out_num !== 4'd1) begin errors++; $display("FAIL abort_at_idx4: got valid=%b num=%0d, required valid=1 num=1", if0.out_valid, if0.out_num); end
      abort0 = 1'b1; tick(1); abort0 = 1'b0;
      checks++; if (if0.out_valid !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL abort_idle: got valid=%b busy=%b, required 0 0", if0.out_valid, busy0); end
      tick(10);
      checks++; if (n_xfer != 5 || n_done != 0 || q0.size() != 0) begin errors++;
         $display("FAIL abort_count: got %0d digits %0d done %0d pending, required 5 0 0", n_xfer, n_done, q0.size()); end
      push0_n(8); go0(1); tick(12);
      checks++; if (n_xfer != 13 || n_done != 1) begin errors++; $display("FAIL abort_restart: got %0d digits %0d done, required 13 1", n_xfer, n_done); end
      // abort together with start in IDLE keeps the block idle
      abort0 = 1'b1; start0 = 1'b1; reps0 = 4'd1; tick(1); abort0 = 1'b0; start0 = 1'b0;
      tick(3);
      checks++; if (busy0 !== 1'b0 || n_xfer != 13) begin errors++; $display("FAIL abort_start_idle: got busy=%b digits=%0d, required 0 13", busy0, n_xfer); end
   endtask

   task automatic test_start_busy_and_reset();
      clear0(); push0_n(8); go0(1); tick(3);
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_high: got %b, required 1", busy0); end
      start0 = 1'b1; tick(1); start0 = 1'b0;
      tick(30);
      checks++; if (n_xfer != 8 || n_done != 1 || q0.size() != 0) begin errors++;
         $display("FAIL start_ignored: got %0d digits %0d done %0d pending, required 8 1 0", n_xfer, n_done, q0.size()); end
      clear0(); push0_n(8); go0(1); tick(3);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({if0.out_valid, if0.out_num, if0.out_last, busy0, done0} !== 8'h00) begin errors++;
         $display("FAIL async_reset: got valid=%b num=%0d last=%b busy=%b, required all 0", if0.out_valid, if0.out_num, if0.out_last, busy0); end
      q0.delete();
      tick(2); rst_n = 1'b1; tick(5);
      checks++; if (if0.out_valid !== 1'b0 || n_xfer != 3) begin errors++; $display("FAIL no_resume: got valid=%b digits=%0d, required 0 3", if0.out_valid, n_xfer); end
      push0_n(8); go0(1); tick(12);
      checks++; if (n_xfer != 11 || n_done != 1) begin errors++; $display("FAIL after_reset: got %0d digits %0d done, required 11 1", n_xfer, n_done); end
   endtask

   task automatic test_gap();
      int nx, nd;
      logic ev;
      logic [4:0] e;
      nx = 0; nd = 0;
      for (int i = 0; i < 16; i++) q2.push_back({((i % 8) == 7), dig[i % 8]});
      if2.out_ready = 1'b1;
      start2 = 1'b1; reps2 = 4'd2; tick(1); start2 = 1'b0;
      for (int k = 1; k <= 55; k++) begin
         @(negedge clk);
         ev = (k <= 46) && ((k - 1) % 3 == 0);
         checks++;
         if (if2.out_valid !== ev) begin errors++; $display("FAIL gap_valid: cycle %0d got %b, required %b", k, if2.out_valid, ev); end
         if (if2.out_valid === 1'b1 && if2.out_ready === 1'b1 && q2.size() != 0) begin
            e = q2.pop_front();
            nx++;
            checks++;
            if ({if2.out_last, if2.out_num} !== e) begin errors++;
               $display("FAIL gap_digit: got num=%0d last=%b, required num=%0d last=%b", if2.out_num, if2.out_last, e[3:0], e[4]); end
         end
         if (done2 === 1'b1) begin
            nd++;
            checks++;
            if (k != 47) begin errors++; $display("FAIL gap_done_cycle: got %0d, required 47", k); end
         end
      end
      checks++; if (nx != 16 || nd != 1 || q2.size() != 0) begin errors++;
         $display("FAIL gap_count: got %0d digits %0d done %0d pending, required 16 1 0", nx, nd, q2.size()); end
      tick(1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_reps();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_start_busy_and_reset();
      test_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
